uart_tx_fifo: RTL and testbench

Byte FIFO and issue controller directly upstream of `UART_Tr_top`. It accepts bytes from the host/core write port at full clock rate and buffers up to DEPTH of them. It then hands the bytes one at a time to the transmitter through its `Data_in`/`TBR_en` inputs, issuing only when the transmitter reports `TBR_Valid` low. It decouples bursty core writes from the serial bit rate and flags dropped writes.

---
 rtl/uart_tx_fifo.sv | 139 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Byte FIFO sitting in front of the UART transmitter. Core writes land at
// full clock rate; a small issue controller hands bytes one at a time to the
// transmitter whenever its holding buffer reports empty (tx_tbr_valid low).
// Dropped writes (FIFO full) raise a sticky overflow flag.

module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          flush,
    input  logic          clr_ovrflw,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [7:0]    tx_wdata,
    output logic          tx_wr,
    input  logic          tx_tbr_valid
);

    localparam int             CW         = AW + 1;
    localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rp_q, rp_d;
    logic [AW-1:0] wp_q, wp_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    tx_wdata_q, tx_wdata_d;
    logic [1:0]    state_q, state_d;

    logic          wr_accept;
    logic          wr_drop;
    logic          pop;

    // Occupancy flags and the three events that drive every register update.
    // full is judged on the pre-edge count, so a write while full is dropped
    // even when a pop frees a slot on that same edge.
    always_comb begin
        full      = (count_q == FULL_COUNT);
        empty     = (count_q == '0);
        wr_accept = wr_en && !full && !flush;
        wr_drop   = wr_en && full && !flush;
        pop       = (state_q == ST_IDLE) && !empty && !tx_tbr_valid && !flush;
    end

    // Pointer, occupancy and overflow next-state; flush wins over everything
    // except the sticky overflow flag, which it leaves alone.
    always_comb begin
        rp_d       = rp_q;
        wp_d       = wp_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (flush) begin
            rp_d    = '0;
            wp_d    = '0;
            count_d = '0;
        end else begin
            if (wr_accept) begin
                wp_d = wp_q + AW'(1);
            end
            if (pop) begin
                rp_d = rp_q + AW'(1);
            end
            case ({wr_accept, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        if (wr_drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovrflw) begin
            overflow_d = 1'b0;
        end
    end

    // Issue controller: pop in IDLE, pulse tx_wr in ISSUE, then give the
    // transmitter one SETTLE cycle to raise its busy flag before looking again.
    always_comb begin
        state_d    = state_q;
        tx_wdata_d = tx_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    tx_wdata_d = mem_q[rp_q];
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE:  state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Storage array; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wp_q] <= wr_data;
        end
    end

    // Control registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp_q       <= '0;
            wp_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_wdata_q <= 8'h00;
            state_q    <= ST_IDLE;
        end else begin
            rp_q       <= rp_d;
            wp_q       <= wp_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_wdata_q <= tx_wdata_d;
            state_q    <= state_d;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;
    assign tx_wdata = tx_wdata_q;
    assign tx_wr    = (state_q == ST_ISSUE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// Directed scenarios plus a randomized run, all compared every cycle against
// a queue-based reference model of the FIFO and its issue pacing.

module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          flush;
    logic          clr_ovrflw;
    logic          tx_tbr_valid;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic [7:0]    tx_wdata;
    logic          tx_wr;

    int            vectors     = 0;
    int            miscompares = 0;
    int            cycleNum    = 0;

    logic [7:0]    modelQ[$];
    int            modelBusy;
    bit            modelOvf;
    logic [7:0]    modelWdata;
    bit            modelTxWr;
    logic [7:0]    issued[$];

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .flush        (flush),
        .clr_ovrflw   (clr_ovrflw),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .tx_wdata     (tx_wdata),
        .tx_wr        (tx_wr),
        .tx_tbr_valid (tx_tbr_valid)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cycleNum);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        modelBusy  = 0;
        modelOvf   = 1'b0;
        modelWdata = 8'h00;
        modelTxWr  = 1'b0;
    endtask

    // One clock edge of the reference: a pop needs at least three edges since
    // the previous pop, data waiting, an idle transmitter and no flush.
    task automatic modelStep();
        bit wasFull;
        bit doPop;
        bit dropped;
        if (!rst_n) begin
            modelReset();
        end else begin
            wasFull = (modelQ.size() == DEPTH);
            doPop   = (modelBusy == 0) && (modelQ.size() > 0) && !tx_tbr_valid && !flush;
            dropped = wr_en && wasFull && !flush;
            modelTxWr = doPop;
            if (doPop) begin
                modelWdata = modelQ.pop_front();
                modelBusy  = 2;
            end else if (modelBusy > 0) begin
                modelBusy--;
            end
            if (flush) begin
                modelQ.delete();
            end else if (wr_en && !wasFull) begin
                modelQ.push_back(wr_data);
            end
            if (dropped) begin
                modelOvf = 1'b1;
            end else if (clr_ovrflw) begin
                modelOvf = 1'b0;
            end
        end
    endtask

    task automatic compareAll();
        checkOutput("count",    32'(count),    32'(modelQ.size()));
        checkOutput("empty",    32'(empty),    32'(modelQ.size() == 0));
        checkOutput("full",     32'(full),     32'(modelQ.size() == DEPTH));
        checkOutput("overflow", 32'(overflow), 32'(modelOvf));
        checkOutput("tx_wr",    32'(tx_wr),    32'(modelTxWr));
        checkOutput("tx_wdata", 32'(tx_wdata), 32'(modelWdata));
    endtask

    // Drive one cycle of inputs, step DUT and model across the edge, compare.
    task automatic applyStimulus(input bit we, input logic [7:0] wd, input bit fl,
                                 input bit clr, input bit tbr);
        wr_en        = we;
        wr_data      = wd;
        flush        = fl;
        clr_ovrflw   = clr;
        tx_tbr_valid = tbr;
        @(posedge clk);
        cycleNum++;
        modelStep();
        #1;
        compareAll();
        if (tx_wr === 1'b1) begin
            issued.push_back(tx_wdata);
        end
    endtask

    initial begin
        int hold;
        int lastPulse;

        rst_n        = 1'b0;
        wr_en        = 1'b0;
        wr_data      = 8'h00;
        flush        = 1'b0;
        clr_ovrflw   = 1'b0;
        tx_tbr_valid = 1'b0;
        modelReset();

        // Reset values while inputs toggle underneath.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_wdata", 32'(tx_wdata), 32'h00);
        rst_n = 1'b1;

        // Single byte through an empty FIFO.
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        checkOutput("single_count", 32'(count), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("single_txwr", 32'(tx_wr), 32'd1);
        checkOutput("single_data", 32'(tx_wdata), 32'hA5);
        checkOutput("single_empty", 32'(empty), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("single_pulse_end", 32'(tx_wr), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset asserted while tx_wr is high must drop it with no clock edge.
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_rst_txwr", 32'(tx_wr), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_async_txwr", 32'(tx_wr), 32'd0);
        compareAll();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        rst_n = 1'b1;

        // Stall with the transmitter busy, then release with 2-cycle busy pulses.
        issued.delete();
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
        checkOutput("stall_count", 32'(count), 32'd5);
        checkOutput("stall_no_issue", 32'(issued.size()), 32'd0);
        hold = 0;
        lastPulse = -100;
        for (int c = 0; c < 40; c++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, hold > 0);
            if (tx_wr === 1'b1) begin
                checkOutput("pulse_gap_ok", 32'((cycleNum - lastPulse) >= 3), 32'd1);
                lastPulse = cycleNum;
                hold = 2;
            end else if (hold > 0) begin
                hold--;
            end
        end
        checkOutput("order_n", 32'(issued.size()), 32'd5);
        for (int i = 0; i < 5 && i < issued.size(); i++) begin
            checkOutput("order_byte", 32'(issued[i]), 32'(i + 1));
        end

        // Fill past capacity; the 17th byte must be dropped and never issued.
        issued.delete();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b1);
            if (i == 15) begin
                checkOutput("fill_full", 32'(full), 32'd1);
                checkOutput("fill_no_ovf", 32'(overflow), 32'd0);
            end
        end
        checkOutput("fill_ovf", 32'(overflow), 32'd1);
        checkOutput("fill_count", 32'(count), 32'd16);
        for (int c = 0; c < 60; c++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("drain_n", 32'(issued.size()), 32'd16);
        for (int i = 0; i < 16 && i < issued.size(); i++) begin
            checkOutput("drain_byte", 32'(issued[i]), 32'(8'h10 + i));
        end

        // Pop and write on the same edge while full: the write is dropped.
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        checkOutput("popfull_count", 32'(count), 32'd15);
        checkOutput("popfull_ovf", 32'(overflow), 32'd1);
        checkOutput("popfull_txwr", 32'(tx_wr), 32'd1);
        applyStimulus(1'b1, 8'hEF, 1'b0, 1'b0, 1'b1);
        checkOutput("refill_count", 32'(count), 32'd16);
        applyStimulus(1'b1, 8'hF0, 1'b0, 1'b1, 1'b1);
        checkOutput("clr_vs_set_ovf", 32'(overflow), 32'd1);

        // Flush beats a simultaneous write and leaves overflow alone.
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
        checkOutput("flush_count", 32'(count), 32'd0);
        checkOutput("flush_empty", 32'(empty), 32'd1);
        checkOutput("flush_ovf", 32'(overflow), 32'd1);

        // Flush during SETTLE: the in-flight byte stands, the queued one is gone.
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        issued.delete();
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h6B, 1'b0, 1'b0, 1'b0);
        checkOutput("settle_txwr", 32'(tx_wr), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("settle_flush_count", 32'(count), 32'd0);
        checkOutput("settle_wdata", 32'(tx_wdata), 32'h5A);
        for (int c = 0; c < 8; c++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("settle_issued_n", 32'(issued.size()), 32'd1);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            applyStimulus($urandom_range(0, 9) < 6, 8'($urandom),
                          $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
                          $urandom_range(0, 9) < 4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
